moto_ramp_seq: RTL and testbench

- Command sequencer that sits between the board keys and the motor PWM stage.
- Debounces the four active-low keys and slews the PWM duty one LSB per ramp tick toward the selected speed.
- Enforces ramp-to-zero plus a dead-time before any direction reversal or stop, so the H-bridge never sees an abrupt reversal.
- Outputs (enable, direction, duty) drive the PWM generator directly.

---
 rtl/moto_ramp_seq_pkg.sv | 20 ++
 rtl/moto_ramp_seq_key_debounce.sv | 40 ++++
 rtl/moto_ramp_seq.sv | 127 ++++++++++++
 tb/tb_moto_ramp_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/moto_ramp_seq_pkg.sv
// Shared definitions for the motor ramp sequencer: FSM states, key indices
// and default speed duties.
package moto_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2,
    ST_DEAD = 2'd3
  } state_t;

  localparam int KEY_RUN = 0;
  localparam int KEY_REV = 1;
  localparam int KEY_SP0 = 2;
  localparam int KEY_SP1 = 3;

  localparam logic [7:0] DEF_SPD0_DUTY = 8'd96;
  localparam logic [7:0] DEF_SPD1_DUTY = 8'd192;

endpackage

// File: rtl/moto_ramp_seq_key_debounce.sv
// One active-low key: 2-FF synchroniser followed by a stable-run counter.
// The output only follows the input after DEB_CYC consecutive differing samples.
module key_debounce #(
  parameter logic [19:0] DEB_CYC = 20'd500000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_raw,
  output logic key_deb
);

  logic        sync1_reg;
  logic        sync2_reg;
  logic        deb_reg;
  logic [19:0] cnt_reg;

  // Keys idle high, so every stage resets to the released level.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      deb_reg   <= 1'b1;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= key_raw;
      sync2_reg <= sync1_reg;
      if (sync2_reg == deb_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == DEB_CYC - 20'd1) begin
        deb_reg <= sync2_reg;
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 20'd1;
      end
    end
  end

  assign key_deb = deb_reg;

endmodule

// File: rtl/moto_ramp_seq.sv
// Key-driven motor command sequencer: debounced keys select speed/direction,
// duty slews one LSB per ramp tick, reversals and stops go through ramp-down + dead time.
module moto_ramp_seq
  import moto_pkg::*;
#(
  parameter int          DUTY_W    = 8,
  parameter logic [DUTY_W-1:0] SPD0_DUTY = DEF_SPD0_DUTY,
  parameter logic [DUTY_W-1:0] SPD1_DUTY = DEF_SPD1_DUTY,
  parameter logic [15:0] RAMP_DIV  = 16'd50000,
  parameter logic [15:0] DEAD_CYC  = 16'd25000,
  parameter logic [19:0] DEB_CYC   = 20'd500000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [3:0]        key,
  output logic              pwm_en,
  output logic              pwm_dir,
  output logic [DUTY_W-1:0] pwm_duty,
  output logic              busy,
  output logic [1:0]        state_o
);

  logic [3:0] key_deb;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_deb
      key_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .key_raw  (key[gi]),
        .key_deb  (key_deb[gi])
      );
    end
  endgenerate

  logic run_req, rev_req, sp0, sp1;
  assign run_req = ~key_deb[KEY_RUN];
  assign rev_req = ~key_deb[KEY_REV];
  assign sp0     = ~key_deb[KEY_SP0];
  assign sp1     = ~key_deb[KEY_SP1];

  logic [DUTY_W-1:0] target;
  always_comb begin
    target = '0;
    if (sp0 && sp1)  target = {DUTY_W{1'b1}};
    else if (sp0)    target = SPD0_DUTY;
    else if (sp1)    target = SPD1_DUTY;
  end

  state_t            state_reg;
  logic              en_reg;
  logic              dir_reg;
  logic [DUTY_W-1:0] duty_reg;
  logic [15:0]       presc_reg;
  logic [15:0]       dead_reg;
  logic              tick;

  assign tick = ((state_reg == ST_RUN) || (state_reg == ST_STOP)) &&
                (presc_reg == RAMP_DIV - 16'd1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg <= ST_IDLE;
      en_reg    <= 1'b0;
      dir_reg   <= 1'b0;
      duty_reg  <= '0;
      presc_reg <= '0;
      dead_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          presc_reg <= '0;
          if (run_req) begin
            dir_reg   <= rev_req;
            en_reg    <= 1'b1;
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          presc_reg <= tick ? 16'd0 : presc_reg + 16'd1;
          // A stop or reversal request wins over a coincident tick.
          if (!run_req || (rev_req != dir_reg)) begin
            state_reg <= ST_STOP;
          end else if (tick) begin
            if (duty_reg < target)      duty_reg <= duty_reg + 1'b1;
            else if (duty_reg > target) duty_reg <= duty_reg - 1'b1;
          end
        end
        ST_STOP: begin
          if (duty_reg == '0) begin
            en_reg    <= 1'b0;
            presc_reg <= '0;
            dead_reg  <= '0;
            state_reg <= ST_DEAD;
          end else begin
            presc_reg <= tick ? 16'd0 : presc_reg + 16'd1;
            if (tick) duty_reg <= duty_reg - 1'b1;
          end
        end
        ST_DEAD: begin
          presc_reg <= '0;
          if (dead_reg == DEAD_CYC - 16'd1) begin
            dead_reg <= '0;
            if (run_req) begin
              dir_reg   <= rev_req;
              en_reg    <= 1'b1;
              state_reg <= ST_RUN;
            end else begin
              state_reg <= ST_IDLE;
            end
          end else begin
            dead_reg <= dead_reg + 16'd1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign pwm_en   = en_reg;
  assign pwm_dir  = dir_reg;
  assign pwm_duty = duty_reg;
  assign busy     = (state_reg != ST_IDLE);
  assign state_o  = state_reg;

endmodule

// File: tb/tb_moto_ramp_seq.sv
// Randomised + directed bench for moto_ramp_seq against a behavioural model.
module tb_moto_ramp_seq;

  localparam int RAMP_DIV = 4;
  localparam int DEAD_CYC = 8;
  localparam int DEB_CYC  = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [3:0] key = 4'hF;
  logic       pwm_en, pwm_dir, busy;
  logic [7:0] pwm_duty;
  logic [1:0] state_o;

  int n_pass = 0;
  int n_total = 0;

  moto_ramp_seq #(
    .RAMP_DIV(16'(RAMP_DIV)),
    .DEAD_CYC(16'(DEAD_CYC)),
    .DEB_CYC (20'(DEB_CYC))
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key      (key),
    .pwm_en   (pwm_en),
    .pwm_dir  (pwm_dir),
    .pwm_duty (pwm_duty),
    .busy     (busy),
    .state_o  (state_o)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int         m_state, m_duty, m_en, m_dir, m_seg, m_dead;
  logic [3:0] m_deb;
  logic [3:0] raw_q[$];
  logic [3:0] win_q[$];

  task automatic model_reset();
    m_state = 0; m_duty = 0; m_en = 0; m_dir = 0; m_seg = 0; m_dead = 0;
    m_deb = 4'hF;
    raw_q = {4'hF, 4'hF};
    win_q = {};
  endtask

  task automatic model_step();
    logic [3:0] s;
    bit run, rev, sp0, sp1, tick, all_diff;
    int tgt;
    run = !m_deb[0]; rev = !m_deb[1]; sp0 = !m_deb[2]; sp1 = !m_deb[3];
    tgt = (sp0 && sp1) ? 255 : sp0 ? 96 : sp1 ? 192 : 0;
    // m_seg counts cycles already spent in the current RUN/STOP stretch
    tick = (m_state == 1 || m_state == 2) && ((m_seg + 1) % RAMP_DIV == 0);
    case (m_state)
      0: if (run) begin m_dir = int'(rev); m_state = 1; m_en = 1; m_seg = 0; end
      1: begin
        m_seg++;
        if (!run || int'(rev) != m_dir) m_state = 2;
        else if (tick) begin
          if (m_duty < tgt) m_duty++;
          else if (m_duty > tgt) m_duty--;
        end
      end
      2: if (m_duty == 0) begin m_state = 3; m_en = 0; m_dead = 0; end
         else begin m_seg++; if (tick) m_duty--; end
      default: begin
        m_dead++;
        if (m_dead == DEAD_CYC) begin
          if (run) begin m_dir = int'(rev); m_state = 1; m_en = 1; m_seg = 0; end
          else m_state = 0;
        end
      end
    endcase
    // debounce: raw seen two cycles late, flips after DEB_CYC differing samples
    raw_q.push_back(key);
    s = raw_q.pop_front();
    win_q.push_back(s);
    if (win_q.size() > DEB_CYC) void'(win_q.pop_front());
    if (win_q.size() == DEB_CYC) begin
      for (int b = 0; b < 4; b++) begin
        all_diff = 1'b1;
        foreach (win_q[i]) if (win_q[i][b] == m_deb[b]) all_diff = 1'b0;
        if (all_diff) m_deb[b] = ~m_deb[b];
      end
    end
  endtask

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) model_reset();
    else model_step();
  end

  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      check("outputs{en,dir,duty,busy,state}",
            int'({pwm_en, pwm_dir, pwm_duty, busy, state_o}),
            (m_en << 12) | (m_dir << 11) | (m_duty << 3) | ((m_state != 0) << 2) | m_state);
    end
  end

  // ---------------- helpers ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic wait_duty(input int val, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge sys_clk);
      if (int'(pwm_duty) == val) break;
    end
    check("wait_duty", int'(pwm_duty), val);
  endtask

  task automatic wait_state(input int val, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge sys_clk);
      if (int'(state_o) == val) break;
    end
    check("wait_state", int'(state_o), val);
  endtask

  task automatic set_key(input logic [3:0] k);
    @(negedge sys_clk);
    key = k;
  endtask

  initial begin
    int hold;
    #3;
    check("reset_outputs", int'({pwm_en, pwm_dir, pwm_duty, busy, state_o}), 0);
    cycles(3);
    sys_rst_n = 1'b1;
    cycles(2);

    // 1: run + speed0; pin debounce/ramp latency
    set_key(4'b1010);
    cycles(6);  check("s1_idle_before_run", int'(state_o), 0);
    cycles(1);  check("s1_run_state", int'(state_o), 1);
    check("s1_dir", int'(pwm_dir), 0);
    cycles(3);  check("s1_duty_before_tick", int'(pwm_duty), 0);
    cycles(1);  check("s1_first_step", int'(pwm_duty), 1);
    cycles(4);  check("s1_second_step", int'(pwm_duty), 2);
    wait_duty(96, 600);
    cycles(20); check("s1_hold_96", int'(pwm_duty), 96);
    check("s1_model_pin", m_duty, 96);

    // 2: speed1 then both speeds
    set_key(4'b0110);
    wait_duty(192, 600);
    set_key(4'b0010);
    wait_duty(255, 400);
    cycles(30); check("s2_hold_255", int'(pwm_duty), 255);

    // 3: back to 96, then reverse
    set_key(4'b1010);
    wait_duty(96, 800);
    set_key(4'b1000);
    wait_state(2, 50);
    check("s3_stop_dir", int'(pwm_dir), 0);
    wait_state(3, 600);
    check("s3_dead_en", int'(pwm_en), 0);
    check("s3_dead_duty", int'(pwm_duty), 0);
    cycles(7);  check("s3_dead_still", int'(state_o), 3);
    cycles(1);  check("s3_rerun", int'(state_o), 1);
    check("s3_rev_dir", int'(pwm_dir), 1);
    wait_duty(96, 600);

    // 4: release run -> idle; then release at 40 and re-press during STOP
    set_key(4'b1011);
    wait_state(0, 800);
    check("s4_busy_idle", int'(busy), 0);
    set_key(4'b1010);
    wait_duty(40, 400);
    set_key(4'b1011);
    wait_state(2, 50);
    set_key(4'b1010);
    cycles(20); check("s4_stop_committed", int'(state_o), 2);
    wait_state(3, 300);
    wait_state(1, 50);
    check("s4_rerun_dir", int'(pwm_dir), 0);

    // 5: short glitch on run while idle
    set_key(4'b1011);
    wait_state(0, 800);
    set_key(4'b1010);
    cycles(2);
    key = 4'b1011;
    cycles(20);
    check("s5_glitch_state", int'(state_o), 0);
    check("s5_glitch_busy", int'(busy), 0);

    // 6: async reset mid-ramp
    set_key(4'b1010);
    wait_duty(50, 400);
    #2 sys_rst_n = 1'b0;
    #1 check("s6_async_reset", int'({pwm_en, pwm_dir, pwm_duty, busy, state_o}), 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    wait_state(1, 50);
    check("s6_restart_duty", int'(pwm_duty), 0);

    // random phase
    for (int n = 0; n < 40; n++) begin
      set_key(4'($urandom_range(0, 15)));
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(10, 300);
      cycles(hold);
    end
    set_key(4'b1111);
    cycles(1500);
    check("final_idle", int'(state_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
